// File: rtl/pixart_init_seq.sv
// -----------------------------------------------------------------------------
// pixart_init_seq
//
// Command sequencer sitting directly in front of i2c_master. After reset, once
// enable is seen with the master idle, it walks a fixed six-entry write table
// that takes the IR camera out of reset and into sensing mode. Each entry is
// presented as addr/data/packets/rw plus a start request. The sequencer then
// waits for the master's ready handshake and a settle gap before moving on.
// When the table completes, done is raised so later stages know the camera is
// live.
//
// Optional feature (macro PIXART_POLL_EN):
//   When defined, the terminal DONE state is replaced by a polling loop. The
//   loop waits POLL_CYCLES, writes 16'h3600 (1 byte), then reads 6 bytes
//   (data 16'h0000, rw=1), and repeats. done stays high and step stays 5.
//   When undefined, DONE is terminal and i2c_rw is tied to 0.
//
// Parameters:
//   I2C_ADDR     7-bit slave address driven on i2c_addr
//   GAP_CYCLES   idle cycles after every completed table write (>=1)
//   ACK_TIMEOUT  max cycles start may wait for ready to fall (>=2)
//   POLL_CYCLES  cycles between poll rounds (PIXART_POLL_EN only)
//
// Ports:
//   clk          system clock (slow_clk domain of the master)
//   reset        asynchronous active-high reset
//   enable       level; sequence starts on first enable=1 seen in IDLE
//   i2c_ready    master ready; 1 = idle/complete, 0 = busy
//   i2c_start    transaction request to master
//   i2c_addr     slave address, constant I2C_ADDR
//   i2c_data     {reg, value}; first byte sent in [15:8]
//   i2c_packets  bytes in transaction
//   i2c_rw       0 = write, 1 = read
//   step         index of current table entry, 0..5
//   done         all six writes complete; sticky until reset
//   error        an ACK_TIMEOUT expired; sticky until reset
//
// state     | meaning
// ----------+----------------------------------------------------------------
// ST_IDLE   | waiting for enable with the master idle
// ST_LOAD   | transaction fields valid, start rises on the next cycle
// ST_REQ    | start held high until the master drops ready (or timeout)
// ST_BUSY   | master working; wait for ready to return
// ST_GAP    | camera settle time after a table write
// ST_DONE   | table complete, terminal (default build)
// ST_FAIL   | handshake timeout, terminal until reset
// ST_POLL   | wait between poll rounds (PIXART_POLL_EN build)
// -----------------------------------------------------------------------------
module pixart_init_seq #(
    parameter logic [6:0] I2C_ADDR    = 7'h58,
    parameter int         GAP_CYCLES  = 1000,
    parameter int         ACK_TIMEOUT = 255,
    parameter int         POLL_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        i2c_ready,
    output logic        i2c_start,
    output logic [6:0]  i2c_addr,
    output logic [15:0] i2c_data,
    output logic [2:0]  i2c_packets,
    output logic        i2c_rw,
    output logic [2:0]  step,
    output logic        done,
    output logic        error
);

    // One down-counter is shared by the timeout, gap and poll timers; it is
    // sized for whichever of them is longest.
    localparam int MAX_GA  = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int MAX_CNT = (MAX_GA > POLL_CYCLES) ? MAX_GA : POLL_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] ACK_LOAD  = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] POLL_LOAD = CW'(POLL_CYCLES - 1);
    localparam logic [2:0]    LAST_STEP = 3'd5;
    localparam logic [2:0]    TBL_PKTS  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_REQ  = 3'd2,
        ST_BUSY = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5,
        ST_FAIL = 3'd6,
        ST_POLL = 3'd7
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    function automatic logic [15:0] table_data(input logic [2:0] idx);
        logic [15:0] d;
        case (idx)
            3'd0:    d = 16'h3001;
            3'd1:    d = 16'h3008;
            3'd2:    d = 16'h0690;
            3'd3:    d = 16'h08C0;
            3'd4:    d = 16'h1A40;
            3'd5:    d = 16'h3333;
            default: d = 16'h0000;
        endcase
        return d;
    endfunction

    assign i2c_addr = I2C_ADDR;

`ifdef PIXART_POLL_EN
    logic rw_q;
    logic poll_rd;   // 0: next poll transaction is the write, 1: the read
    assign i2c_rw = rw_q;
`else
    assign i2c_rw = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            i2c_start   <= 1'b0;
            i2c_data    <= 16'h0000;
            i2c_packets <= 3'd0;
            step        <= 3'd0;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef PIXART_POLL_EN
            rw_q        <= 1'b0;
            poll_rd     <= 1'b0;
`endif
        end else begin
            case (state)
                // Fields are loaded on the way into LOAD so they are already
                // stable for a full cycle before start rises.
                ST_IDLE: begin
                    if (enable && i2c_ready) begin
                        i2c_data    <= table_data(step);
                        i2c_packets <= TBL_PKTS;
`ifdef PIXART_POLL_EN
                        rw_q        <= 1'b0;
`endif
                        state       <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    i2c_start <= 1'b1;
                    cnt       <= ACK_LOAD;
                    state     <= ST_REQ;
                end

                // Accept wins over timeout when both land on the same cycle.
                ST_REQ: begin
                    if (!i2c_ready) begin
                        i2c_start <= 1'b0;
                        state     <= ST_BUSY;
                    end else if (cnt == '0) begin
                        i2c_start <= 1'b0;
                        error     <= 1'b1;
                        done      <= 1'b0;
                        state     <= ST_FAIL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_BUSY: begin
                    if (i2c_ready) begin
`ifdef PIXART_POLL_EN
                        // done is only set once the table is finished, so it
                        // separates poll traffic from table traffic here.
                        if (done) begin
                            if (!poll_rd) begin
                                poll_rd     <= 1'b1;
                                i2c_data    <= 16'h0000;
                                i2c_packets <= 3'd6;
                                rw_q        <= 1'b1;
                                state       <= ST_LOAD;
                            end else begin
                                poll_rd <= 1'b0;
                                cnt     <= POLL_LOAD;
                                state   <= ST_POLL;
                            end
                        end else begin
                            cnt   <= GAP_LOAD;
                            state <= ST_GAP;
                        end
`else
                        cnt   <= GAP_LOAD;
                        state <= ST_GAP;
`endif
                    end
                end

                ST_GAP: begin
                    if (cnt == '0) begin
                        if (step == LAST_STEP) begin
                            done  <= 1'b1;
`ifdef PIXART_POLL_EN
                            cnt   <= POLL_LOAD;
                            state <= ST_POLL;
`else
                            state <= ST_DONE;
`endif
                        end else begin
                            step        <= step + 3'd1;
                            i2c_data    <= table_data(step + 3'd1);
                            i2c_packets <= TBL_PKTS;
                            state       <= ST_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_POLL: begin
`ifdef PIXART_POLL_EN
                    if (cnt == '0) begin
                        i2c_data    <= 16'h3600;
                        i2c_packets <= 3'd1;
                        rw_q        <= 1'b0;
                        state       <= ST_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
`else
                    state <= ST_POLL;
`endif
                end

                ST_DONE: state <= ST_DONE;
                ST_FAIL: state <= ST_FAIL;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixart_init_seq.sv
`timescale 1ns/1ps
module tb_pixart_init_seq;

    localparam int GAP   = 20;
    localparam int ACK   = 10;
    localparam int POLL  = 60;
    localparam int NSTEP = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        i2c_ready = 1'b1;
    logic        i2c_start;
    logic [6:0]  i2c_addr;
    logic [15:0] i2c_data;
    logic [2:0]  i2c_packets;
    logic        i2c_rw;
    logic [2:0]  step;
    logic        done;
    logic        error;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // Reference table of the camera bring-up writes.
    logic [15:0] exp_data [NSTEP];

    always #5 clk = ~clk;

    pixart_init_seq #(
        .I2C_ADDR   (7'h58),
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(ACK),
        .POLL_CYCLES(POLL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .i2c_ready  (i2c_ready),
        .i2c_start  (i2c_start),
        .i2c_addr   (i2c_addr),
        .i2c_data   (i2c_data),
        .i2c_packets(i2c_packets),
        .i2c_rw     (i2c_rw),
        .step       (step),
        .done       (done),
        .error      (error)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // Outputs are sampled and inputs driven 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        i2c_ready = 1'b1;
        tick_n(2);
        reset = 1'b0;
        tick();
    endtask

    // Waits (bounded) for start; s = -1 on expiry. pre is i2c_data on the
    // cycle before start was first seen high.
    task automatic wait_start(input int budget, output int s, output logic [15:0] pre);
        s = -1;
        pre = i2c_data;
        for (int i = 0; i < budget; i++) begin
            if (i2c_start === 1'b1) begin
                s = cyc;
                break;
            end
            pre = i2c_data;
            tick();
        end
    endtask

    // Acts as the master for one transaction whose start is high this cycle:
    // drops ready d cycles later, holds it low for busy cycles, then raises it.
    task automatic serve(input logic [15:0] ed, input logic [2:0] ep, input logic erw,
                         input logic [2:0] estep, input int d, input int busy, output int rise);
        tests_run++;
        if (i2c_data !== ed) begin tests_failed++; $display("FAIL txn_data: got %h expected %h", i2c_data, ed); end
        tests_run++;
        if (i2c_packets !== ep) begin tests_failed++; $display("FAIL txn_packets: got %0d expected %0d", i2c_packets, ep); end
        tests_run++;
        if (i2c_rw !== erw) begin tests_failed++; $display("FAIL txn_rw: got %b expected %b", i2c_rw, erw); end
        tests_run++;
        if (i2c_addr !== 7'h58) begin tests_failed++; $display("FAIL txn_addr: got %h expected 58", i2c_addr); end
        tests_run++;
        if (step !== estep) begin tests_failed++; $display("FAIL txn_step: got %0d expected %0d", step, estep); end
        for (int i = 0; i < d; i++) begin
            tick();
            tests_run++;
            if (i2c_start !== 1'b1) begin tests_failed++; $display("FAIL start_hold: got %b expected 1 at hold cycle %0d", i2c_start, i + 1); end
        end
        i2c_ready = 1'b0;
        tick();
        tests_run++;
        if (i2c_start !== 1'b0) begin tests_failed++; $display("FAIL start_drop: got %b expected 0", i2c_start); end
        for (int i = 1; i < busy; i++) begin
            tick();
            tests_run++;
            if (i2c_start !== 1'b0) begin tests_failed++; $display("FAIL busy_quiet: got start=%b expected 0", i2c_start); end
        end
        i2c_ready = 1'b1;
        rise = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick_n(2);
        tests_run++;
        if (i2c_start !== 1'b0) begin tests_failed++; $display("FAIL rst_start: got %b expected 0", i2c_start); end
        tests_run++;
        if (i2c_data !== 16'h0000) begin tests_failed++; $display("FAIL rst_data: got %h expected 0000", i2c_data); end
        tests_run++;
        if (i2c_packets !== 3'd0) begin tests_failed++; $display("FAIL rst_packets: got %0d expected 0", i2c_packets); end
        tests_run++;
        if (i2c_rw !== 1'b0) begin tests_failed++; $display("FAIL rst_rw: got %b expected 0", i2c_rw); end
        tests_run++;
        if (step !== 3'd0) begin tests_failed++; $display("FAIL rst_step: got %0d expected 0", step); end
        tests_run++;
        if ({done, error} !== 2'b00) begin tests_failed++; $display("FAIL rst_flags: got done/error=%b expected 00", {done, error}); end
        tests_run++;
        if (i2c_addr !== 7'h58) begin tests_failed++; $display("FAIL rst_addr: got %h expected 58", i2c_addr); end
        reset = 1'b0;
        tick_n(8);
        tests_run++;
        if (i2c_start !== 1'b0) begin tests_failed++; $display("FAIL idle_no_enable: got start=%b expected 0", i2c_start); end
    endtask

    task automatic test_sequence();
        int s, e, rise, dn, d, busy, starts;
        logic [15:0] pre;
        rise = 0;
        do_reset();
        enable = 1'b1;
        e = cyc;
        for (int k = 0; k < NSTEP; k++) begin
            wait_start(GAP + 20, s, pre);
            tests_run++;
            if (s < 0) begin tests_failed++; $display("FAIL seq_start_timeout: step %0d got no start expected one", k); return; end
            if (k == 0) begin
                tests_run++;
                if (s - e != 2) begin tests_failed++; $display("FAIL enable_latency: got %0d expected 2", s - e); end
            end else begin
                tests_run++;
                if (s - rise != GAP + 2) begin tests_failed++; $display("FAIL start_spacing: step %0d got %0d expected %0d", k, s - rise, GAP + 2); end
            end
            tests_run++;
            if (pre !== exp_data[k]) begin tests_failed++; $display("FAIL data_pre_start: step %0d got %h expected %h", k, pre, exp_data[k]); end
            tests_run++;
            if (done !== 1'b0) begin tests_failed++; $display("FAIL early_done: step %0d got %b expected 0", k, done); end
            if (k == 1) enable = 1'b0;   // must not abort the walk
            d = $urandom_range(ACK - 2, 0);
            busy = (k == 0) ? 40 : $urandom_range(45, 1);
            serve(exp_data[k], 3'd2, 1'b0, 3'(k), d, busy, rise);
        end
        dn = -1;
        for (int i = 0; i < GAP + 20; i++) begin
            if (done === 1'b1) begin dn = cyc; break; end
            tick();
        end
        tests_run++;
        if (dn - rise != GAP + 1) begin tests_failed++; $display("FAIL done_latency: got %0d expected %0d", dn - rise, GAP + 1); end
        tests_run++;
        if (error !== 1'b0) begin tests_failed++; $display("FAIL seq_error: got %b expected 0", error); end
        tests_run++;
        if (step !== 3'd5) begin tests_failed++; $display("FAIL final_step: got %0d expected 5", step); end
`ifdef PIXART_POLL_EN
        begin
            int pe;
            pe = dn;
            for (int r = 0; r < 2; r++) begin
                wait_start(POLL + 20, s, pre);
                tests_run++;
                if (s - pe != POLL + 1) begin tests_failed++; $display("FAIL poll_wr_time: round %0d got %0d expected %0d", r, s - pe, POLL + 1); end
                if (s < 0) return;
                serve(16'h3600, 3'd1, 1'b0, 3'd5, $urandom_range(ACK - 2, 0), $urandom_range(30, 1), rise);
                wait_start(20, s, pre);
                tests_run++;
                if (s - rise != 2) begin tests_failed++; $display("FAIL poll_rd_time: round %0d got %0d expected 2", r, s - rise); end
                if (s < 0) return;
                serve(16'h0000, 3'd6, 1'b1, 3'd5, $urandom_range(ACK - 2, 0), $urandom_range(30, 1), rise);
                tests_run++;
                if (done !== 1'b1) begin tests_failed++; $display("FAIL poll_done: got %b expected 1", done); end
                pe = rise + 1;
            end
        end
`else
        starts = 0;
        enable = 1'b1;
        for (int i = 0; i < POLL + 3 * GAP; i++) begin
            tick();
            if (i2c_start === 1'b1) starts++;
        end
        tests_run++;
        if (starts != 0) begin tests_failed++; $display("FAIL start_after_done: got %0d expected 0", starts); end
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL done_sticky: got %b expected 1", done); end
`endif
    endtask

    task automatic test_ready_busy();
        int s, r, hold, starts;
        logic [15:0] pre;
        do_reset();
        i2c_ready = 1'b0;
        enable = 1'b1;
        hold = $urandom_range(30, 5);
        starts = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (i2c_start === 1'b1) starts++;
        end
        tests_run++;
        if (starts != 0) begin tests_failed++; $display("FAIL start_on_busy: got %0d starts expected 0", starts); end
        i2c_ready = 1'b1;
        r = cyc;
        wait_start(20, s, pre);
        tests_run++;
        if (s - r != 2) begin tests_failed++; $display("FAIL ready_latency: got %0d expected 2", s - r); end
        tests_run++;
        if (i2c_data !== 16'h3001) begin tests_failed++; $display("FAIL ready_first_data: got %h expected 3001", i2c_data); end
    endtask

    task automatic test_timeout();
        int s, hi, starts;
        logic [15:0] pre;
        do_reset();
        enable = 1'b1;
        wait_start(20, s, pre);
        hi = 0;
        for (int i = 0; i < ACK + 20; i++) begin
            if (i2c_start !== 1'b1) break;
            hi++;
            tick();
        end
        tests_run++;
        if (hi != ACK) begin tests_failed++; $display("FAIL timeout_width: got %0d expected %0d", hi, ACK); end
        tests_run++;
        if (error !== 1'b1) begin tests_failed++; $display("FAIL timeout_error: got %b expected 1", error); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL timeout_done: got %b expected 0", done); end
        starts = 0;
        for (int i = 0; i < GAP + 3 * ACK; i++) begin
            tick();
            if (i2c_start === 1'b1) starts++;
        end
        tests_run++;
        if (starts != 0) begin tests_failed++; $display("FAIL start_after_fail: got %0d expected 0", starts); end
        tests_run++;
        if (error !== 1'b1) begin tests_failed++; $display("FAIL error_sticky: got %b expected 1", error); end
    endtask

    task automatic test_reset_busy();
        int s, r, rise;
        logic [15:0] pre;
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_start(GAP + 20, s, pre);
            if (s < 0) begin
                tests_run++; tests_failed++;
                $display("FAIL rb_start_timeout: step %0d got no start expected one", k);
                return;
            end
            serve(exp_data[k], 3'd2, 1'b0, 3'(k), $urandom_range(ACK - 2, 0), $urandom_range(20, 1), rise);
        end
        wait_start(GAP + 20, s, pre);
        tests_run++;
        if (i2c_data !== exp_data[3] || step !== 3'd3) begin tests_failed++; $display("FAIL rb_step3: got %h/%0d expected %h/3", i2c_data, step, exp_data[3]); end
        i2c_ready = 1'b0;
        tick_n(3);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({i2c_start, i2c_data, i2c_packets, i2c_rw, step, done, error} !== 25'd0) begin
            tests_failed++;
            $display("FAIL rb_async_clear: got start=%b data=%h pk=%0d rw=%b step=%0d done=%b err=%b expected all 0",
                     i2c_start, i2c_data, i2c_packets, i2c_rw, step, done, error);
        end
        tick();
        reset = 1'b0;
        tick_n(5);
        tests_run++;
        if (i2c_start !== 1'b0) begin tests_failed++; $display("FAIL rb_wait_ready: got start=%b expected 0", i2c_start); end
        i2c_ready = 1'b1;
        r = cyc;
        wait_start(20, s, pre);
        tests_run++;
        if (s - r != 2) begin tests_failed++; $display("FAIL rb_restart_latency: got %0d expected 2", s - r); end
        tests_run++;
        if (i2c_data !== 16'h3001 || step !== 3'd0) begin tests_failed++; $display("FAIL rb_restart_data: got %h/%0d expected 3001/0", i2c_data, step); end
    endtask

    initial begin
        exp_data[0] = 16'h3001;
        exp_data[1] = 16'h3008;
        exp_data[2] = 16'h0690;
        exp_data[3] = 16'h08C0;
        exp_data[4] = 16'h1A40;
        exp_data[5] = 16'h3333;
        #1;
        test_reset();
        test_sequence();
        test_ready_busy();
        test_timeout();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
